tlb_store: RTL
==============

# tlb_store

Parametrised TLB entry store for the MMU, successor to the fixed 32-entry TLB memory. It holds TLBNUM entries with configurable physical address width, serves the same combinational read and broadcast views, and adds a fill-index counter for TLBFILL. INVTLB is handled by a multi-cycle walk engine that scans LANES entries per cycle behind a valid/ready handshake and honours huge-page (ps=21) VA matching. It sits between the CSR/TLB-instruction unit (write, read, invalidate) and the fetch/load-store lookup logic, which consumes `all_entry`.

## Interface
- TLBNUM, 32, entry count; power of 2, at least LANES
- LANES, 4, entries examined per walk cycle; power of 2, divides TLBNUM
- PALEN, 32, physical address width; PFN width PW = PALEN-12
- Derived: IW = $clog2(TLBNUM); G = TLBNUM/LANES; EW = 37 + 2*(PW+6)
- Entry layout, MSB→LSB: vpn2[18:0], asid[9:0], ps[5:0], g, e, pfn0[PW-1:0], mat0[1:0], plv0[1:0], d0, v0, pfn1[PW-1:0], mat1[1:0], plv1[1:0], d1, v1

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; synchronous, active-high
- all_entry  out  TLBNUM*EW  every entry, with entry i at [i*EW +: EW]
- r_index  in  IW  read index
- r_entry  out  EW  entry at r_index, combinational; every field except e is forced to 0 when e=0
- we  in  1  write strobe
- w_fill  in  1  when 1, the write targets fill_index and w_index is ignored
- w_index  in  IW  write index
- w_entry  in  EW  write data
- fill_index  out  IW  next TLBFILL slot
- inv_valid  in  1  invalidate request
- inv_ready  out  1  engine idle
- inv_op  in  3  INVTLB op
- inv_asid  in  10  ASID operand
- inv_va  in  32  VA operand
- inv_done  out  1  one-cycle completion pulse
- inv_err  out  1  pulses together with inv_done when the op is illegal
- busy  out  1  walk in progress (= !inv_ready)
- inv_count  out  IW+1  number of entries cleared by the last op

## Operation
- Reset state: every e=0; all other entry fields undefined. Outputs after reset: fill_index=0, state IDLE, inv_ready=1, inv_done=0, inv_err=0, inv_count=0.
- Write: on we, the target entry is loaded with w_entry. When w_fill=1 the target is fill_index, and fill_index then increments, wrapping from TLBNUM-1 to 0.
- FSM states and transitions:
  - IDLE → WALK when inv_valid & inv_ready. The engine latches op, asid and va, and sets cursor=0. inv_valid is ignored outside IDLE.
  - WALK: examines entries cursor..cursor+LANES-1. Any entry with e=1 that matches has its e cleared. cursor advances by LANES; after group G-1 the state moves to DONE.
  - DONE: inv_done=1 (plus inv_err=1 if the op is illegal), then → IDLE.
- Match rule per op:
  - op 0 or 1: all entries
  - op 2: g=1
  - op 3: g=0
  - op 4: g=0 & asid match
  - op 5: g=0 & asid match & VA match
  - op 6: (g=1 | asid match) & VA match
  - op 7: illegal; the walk still runs, no entry changes, inv_err is set
- VA match:
  - ps=21: vpn2[18:9] == va[31:22]
  - any other ps: vpn2 == va[31:13]
- Simultaneous write and walk: if we targets an entry in the group being walked that cycle, the write wins. The new entry is not cleared and is not counted.
- Reads and all_entry reflect stored state only and remain valid during a walk.
- rst during a walk: the walk aborts, state returns to IDLE, no inv_done pulse, every e=0.

## Timing
- Handshake in cycle 0. Cycles 1..G are WALK, with group k evaluated in cycle k+1 and e updated at the end of that cycle. inv_done is asserted in cycle G+1. inv_ready returns in cycle G+2.
- Default G=8: inv_done in cycle 9.
- Writes and fill_index updates take effect at the next edge. Reads have zero latency.

## Configuration
- TLB_INV_STAT_EN defined:
  - inv_count is cleared at accept.
  - It then adds the number of entries cleared in each WALK cycle.
  - Its value is final when inv_done is asserted, and it is held until the next accept.
- TLB_INV_STAT_EN undefined: the port remains and inv_count is constant 0. No counter logic is built.

## Test plan
- Reset: assert rst for 2 cycles, then release. Required: inv_ready=1, every e bit in all_entry = 0, fill_index=0.
- Fill all 32 entries with e=1 and g = index odd; op 2 accepted in cycle 0. Required: inv_done in cycle 9; odd entries e=0, even entries e=1; inv_count=16 (with TLB_INV_STAT_EN).
- Setup for op 5:
  - idx3: ps=21, vpn2=0x300, asid 5
  - idx4: ps=12, vpn2=0x200, asid 5
  - idx5: ps=12, vpn2=0x201, asid 6
  
  Issue op 5 with asid=5, va=0x0040_2000. Required: only idx3 is cleared; inv_count=1.
- Issue op 1 and, in cycle 2, write entry 5 with e=1. Required: after inv_done, entry 5 has e=1 and every other entry has e=0.
- Issue three we with w_fill=1. Required: entries 0, 1, 2 written, fill_index=3. Continuing to 32 fills wraps fill_index to 0. op 7 then gives inv_done=inv_err=1 with no e change.
- Assert rst in cycle 4 of an op 3 walk. Required: next cycle inv_ready=1, no inv_done pulse, all e=0, inv_count=0.

Source files
------------

// File: rtl/tlb_store.sv
// tlb_store: parametrised TLB entry store with fill counter and multi-cycle INVTLB walk engine
// Ports: clk/rst (sync, active-high); all_entry (flat view of every entry, e bit live);
// r_index/r_entry (combinational read, zeroed when e=0); we/w_fill/w_index/w_entry (write,
// w_fill targets fill_index and advances it); fill_index; inv_valid/inv_ready/inv_op/
// inv_asid/inv_va (invalidate request); inv_done/inv_err (completion pulse); busy; inv_count.
// Optional: TLB_INV_STAT_EN builds the inv_count counter; otherwise inv_count is tied to 0.
module tlb_store #(
  parameter int TLBNUM = 32,
  parameter int LANES = 4,
  parameter int PALEN = 32,
  localparam int IW = $clog2(TLBNUM),
  localparam int PW = PALEN - 12,
  localparam int G = TLBNUM / LANES,
  localparam int EW = 37 + 2 * (PW + 6)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [TLBNUM*EW-1:0] all_entry,
  input  logic [IW-1:0]        r_index,
  output logic [EW-1:0]        r_entry,
  input  logic                 we,
  input  logic                 w_fill,
  input  logic [IW-1:0]        w_index,
  input  logic [EW-1:0]        w_entry,
  output logic [IW-1:0]        fill_index,
  input  logic                 inv_valid,
  output logic                 inv_ready,
  input  logic [2:0]           inv_op,
  input  logic [9:0]           inv_asid,
  input  logic [31:0]          inv_va,
  output logic                 inv_done,
  output logic                 inv_err,
  output logic                 busy,
  output logic [IW:0]          inv_count
);
  localparam int EB = 2 * (PW + 6);
  localparam int GW = G > 1 ? $clog2(G) : 1;
  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;
  state_t state, state_n;
  // e lives in its own vector so reset and invalidation only touch one bit per entry
  logic [EW-2:0] mem [TLBNUM];
  logic [EW-1:0] ent [TLBNUM];
  logic [TLBNUM-1:0] ev, clr;
  logic [GW-1:0] grp;
  logic [2:0] op;
  logic [9:0] asid;
  logic [31:13] va;
  logic [IW-1:0] widx;
  logic unused_va;
  assign unused_va = ^inv_va[12:0];
  assign widx = w_fill ? fill_index : w_index;
  function automatic logic hit(input logic [EW-1:0] en);
    logic g, am, vm;
    g = en[EB+1];
    am = en[EB+8 +: 10] == asid;
    vm = en[EB+2 +: 6] == 6'd21 ? en[EB+27 +: 10] == va[31:22] : en[EB+18 +: 19] == va[31:13];
    hit = op < 3'd2 ? 1'b1 :
          op == 3'd2 ? g :
          op == 3'd3 ? !g :
          op == 3'd4 ? !g && am :
          op == 3'd5 ? !g && am && vm :
          op == 3'd6 ? (g || am) && vm : 1'b0;
  endfunction
  function automatic logic [IW-1:0] slot(input int l);
    return IW'(int'(grp) * LANES + l);
  endfunction
  for (genvar i = 0; i < TLBNUM; i++) begin : g_ent
    assign ent[i] = {mem[i][EW-2:EB], ev[i], mem[i][EB-1:0]};
    assign all_entry[i*EW +: EW] = ent[i];
  end
  assign r_entry = ev[r_index] ? ent[r_index] : '0;
  assign inv_ready = state == IDLE;
  assign busy = !inv_ready;
  assign inv_done = state == DONE;
  assign inv_err = inv_done && op == 3'd7;
  // a write landing in the group under walk wins over the clear and is not counted
  always_comb begin
    state_n = state == IDLE ? (inv_valid ? WALK : IDLE) :
              state == WALK ? (grp == GW'(G - 1) ? DONE : WALK) : IDLE;
    clr = '0;
    if (state == WALK)
      for (int l = 0; l < LANES; l++)
        clr[slot(l)] = ev[slot(l)] && hit(ent[slot(l)]) && !(we && widx == slot(l));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grp <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && inv_valid) begin
        op <= inv_op;
        asid <= inv_asid;
        va <= inv_va[31:13];
        grp <= '0;
      end else if (state == WALK) grp <= grp + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ev <= '0;
      fill_index <= '0;
    end else begin
      ev <= ev & ~clr;
      if (we) ev[widx] <= w_entry[EB];
      if (we && w_fill) fill_index <= fill_index + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (we) mem[widx] <= {w_entry[EW-1:EB+1], w_entry[EB-1:0]};
`ifdef TLB_INV_STAT_EN
  logic [IW:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (state == IDLE && inv_valid) cnt <= '0;
    else if (state == WALK) cnt <= cnt + (IW+1)'($countones(clr));
  end
  assign inv_count = cnt;
`else
  assign inv_count = '0;
`endif
endmodule
